// File: rtl/filter_select_pkg.sv
// Shared definitions for the filter-selection screen.
// Holds the browse/confirm state type, the option count and select width,
// the box origin coordinates used to place the selection arrow, and the
// wrap-around step helper.
package filter_select_pkg;

    typedef enum logic [0:0] {
        BROWSE    = 1'b0,
        CONFIRMED = 1'b1
    } sel_state_t;

    localparam int NUM_FILTERS = 6;
    localparam int SEL_W       = 3;

    // Box origins on screen, used by the compositor for arrow placement.
    localparam logic [10:0] BOX_X0 = 11'd120;
    localparam logic [10:0] BOX_X1 = 11'd460;
    localparam logic [10:0] BOX_X2 = 11'd800;
    localparam logic [10:0] BOX_Y  = 11'd334;

    // One step of the selection index with explicit wrap at num_opts-1.
    // Overflow of the 3-bit field is never relied on, so 6 and 7 stay unreachable.
    function automatic logic [SEL_W-1:0] sel_step(
        input logic [SEL_W-1:0] cur,
        input logic             dir_right,
        input int unsigned      num_opts
    );
        logic [SEL_W-1:0] last_v;
        logic [SEL_W-1:0] next_v;
        last_v = SEL_W'(num_opts - 32'd1);
        if (dir_right) begin
            if (cur == last_v) begin
                next_v = {SEL_W{1'b0}};
            end else begin
                next_v = cur + SEL_W'(1'b1);
            end
        end else begin
            if (cur == {SEL_W{1'b0}}) begin
                next_v = last_v;
            end else begin
                next_v = cur - SEL_W'(1'b1);
            end
        end
        return next_v;
    endfunction

endpackage

// File: rtl/filter_select_ctrl_if.sv
// Button/selection bundle between the front panel and the compositor.
//   btn_*_in      : raw push-buttons, asynchronous to the pixel clock
//   left_out      : one-cycle pulse per accepted left step
//   right_out     : one-cycle pulse per accepted right step
//   select_out    : registered selection index 0..NUM_FILTERS-1
//   changed_out   : one-cycle pulse when select_out takes a new value
//   confirmed_out : level, high while the selection is confirmed
// slave  : the controller side (consumes buttons, drives selection)
// master : the environment side (drives buttons, observes selection)
interface filter_select_ctrl_if;
    import filter_select_pkg::*;

    logic             btn_left_in;
    logic             btn_right_in;
    logic             btn_confirm_in;
    logic             left_out;
    logic             right_out;
    logic [SEL_W-1:0] select_out;
    logic             changed_out;
    logic             confirmed_out;

    modport slave (
        input  btn_left_in, btn_right_in, btn_confirm_in,
        output left_out, right_out, select_out, changed_out, confirmed_out
    );

    modport master (
        output btn_left_in, btn_right_in, btn_confirm_in,
        input  left_out, right_out, select_out, changed_out, confirmed_out
    );
endinterface

// File: rtl/button_debounce.sv
// Synchroniser + debouncer for one raw push-button.
//   clk_in    : pixel clock
//   rst_n_in  : asynchronous active-low reset
//   btn_in    : raw button level, asynchronous to clk_in
//   press_out : one-cycle pulse on each debounced 0->1 transition
// The debounced level only flips after DEBOUNCE_CYCLES consecutive cycles in
// which the synchronised input disagrees with it; releases produce no pulse.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 742_500
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic btn_in,
    output logic press_out
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    // Next-state: counter runs only while the synchronised input disagrees.
    always_comb begin
        sync1_d = btn_in;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync2_q == level_q) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (cnt_q == CNT_MAX) begin
            level_d = ~level_q;
            cnt_d   = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q + CNT_W'(1'b1);
        end
        // Registered with the level flip so the pulse lands the cycle level rises.
        press_d = level_d & ~level_q;
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press_out = press_q;
endmodule

// File: rtl/filter_select_ctrl.sv
// Button front-end for the filter-selection screen.
//   clk_in   : pixel clock, the only clock in the block
//   rst_n_in : asynchronous active-low reset
//   bus      : slave side of filter_select_ctrl_if (raw buttons in,
//              step pulses / select index / confirm level out)
// Debounces left/right/confirm and runs the browse/confirm state machine.
// Every output is a flop so the compositor sees no combinational path
// back from the buttons.
module filter_select_ctrl
    import filter_select_pkg::*;
#(
    parameter int          DEBOUNCE_CYCLES = 742_500,
    parameter int unsigned NUM_OPTIONS     = NUM_FILTERS
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    filter_select_ctrl_if.slave  bus
);
    logic left_press_s;
    logic right_press_s;
    logic confirm_press_s;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_left (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .btn_in    (bus.btn_left_in),
        .press_out (left_press_s)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_right (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .btn_in    (bus.btn_right_in),
        .press_out (right_press_s)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_confirm (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .btn_in    (bus.btn_confirm_in),
        .press_out (confirm_press_s)
    );

    sel_state_t       state_q,     state_d;
    logic [SEL_W-1:0] select_q,    select_d;
    logic             left_q,      left_d;
    logic             right_q,     right_d;
    logic             changed_q,   changed_d;
    logic             confirmed_q, confirmed_d;

    // Browse/confirm decisions; confirm outranks steps, simultaneous
    // left+right cancel each other.
    always_comb begin
        state_d   = state_q;
        select_d  = select_q;
        left_d    = 1'b0;
        right_d   = 1'b0;
        changed_d = 1'b0;
        case (state_q)
            BROWSE: begin
                if (confirm_press_s) begin
                    state_d = CONFIRMED;
                end else if (right_press_s && !left_press_s) begin
                    select_d  = sel_step(select_q, 1'b1, NUM_OPTIONS);
                    right_d   = 1'b1;
                    changed_d = 1'b1;
                end else if (left_press_s && !right_press_s) begin
                    select_d  = sel_step(select_q, 1'b0, NUM_OPTIONS);
                    left_d    = 1'b1;
                    changed_d = 1'b1;
                end else begin
                    state_d = BROWSE;
                end
            end
            CONFIRMED: begin
                if (confirm_press_s) begin
                    state_d = BROWSE;
                end else begin
                    state_d = CONFIRMED;
                end
            end
            default: begin
                state_d = BROWSE;
            end
        endcase
        confirmed_d = (state_d == CONFIRMED);
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= BROWSE;
            select_q    <= {SEL_W{1'b0}};
            left_q      <= 1'b0;
            right_q     <= 1'b0;
            changed_q   <= 1'b0;
            confirmed_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            select_q    <= select_d;
            left_q      <= left_d;
            right_q     <= right_d;
            changed_q   <= changed_d;
            confirmed_q <= confirmed_d;
        end
    end

    assign bus.left_out      = left_q;
    assign bus.right_out     = right_q;
    assign bus.select_out    = select_q;
    assign bus.changed_out   = changed_q;
    assign bus.confirmed_out = confirmed_q;
endmodule

// File: tb/tb_filter_select_ctrl.sv
// Scoreboard bench for filter_select_ctrl with a short debounce window.
// Stimulus pushes the hand-computed expected output event (cycle, pulses,
// select, confirm level); the monitor pops one entry whenever the DUT shows a
// pulse or a confirm-level change and compares it.
module tb_filter_select_ctrl;
    localparam int DEB = 4;

    typedef struct {
        int         cyc;
        logic       l;
        logic       r;
        logic       ch;
        logic [2:0] sel;
        logic       conf;
    } evt_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    evt_t exp_q[$];

    filter_select_ctrl_if bus();

    filter_select_ctrl #(.DEBOUNCE_CYCLES(DEB), .NUM_OPTIONS(6)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // which: 0 left, 1 right, 2 confirm, 3 left+right
    task automatic press(input int which, input int hold, input bit has_evt,
                         input logic l, input logic r, input logic ch,
                         input logic [2:0] sel, input logic conf);
        evt_t e;
        @(negedge clk);
        if (has_evt) begin
            e.cyc  = cyc + DEB + 3;
            e.l    = l;
            e.r    = r;
            e.ch   = ch;
            e.sel  = sel;
            e.conf = conf;
            exp_q.push_back(e);
        end
        case (which)
            0:       bus.btn_left_in = 1'b1;
            1:       bus.btn_right_in = 1'b1;
            2:       bus.btn_confirm_in = 1'b1;
            3:       begin bus.btn_left_in = 1'b1; bus.btn_right_in = 1'b1; end
            default: ;
        endcase
        repeat (hold) @(negedge clk);
        bus.btn_left_in    = 1'b0;
        bus.btn_right_in   = 1'b0;
        bus.btn_confirm_in = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    // Monitor / scoreboard
    initial begin
        logic prev_conf;
        evt_t e;
        prev_conf = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.left_out || bus.right_out || bus.changed_out ||
                (bus.confirmed_out != prev_conf)) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event: cyc=%0d l=%b r=%b ch=%b sel=%0d conf=%b, expected no event",
                             cyc, bus.left_out, bus.right_out, bus.changed_out,
                             bus.select_out, bus.confirmed_out);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.l != bus.left_out || e.r != bus.right_out ||
                        e.ch != bus.changed_out || e.sel != bus.select_out ||
                        e.conf != bus.confirmed_out) begin
                        n_fail++;
                        $display("FAIL event: got cyc=%0d l=%b r=%b ch=%b sel=%0d conf=%b expected cyc=%0d l=%b r=%b ch=%b sel=%0d conf=%b",
                                 cyc, bus.left_out, bus.right_out, bus.changed_out,
                                 bus.select_out, bus.confirmed_out,
                                 e.cyc, e.l, e.r, e.ch, e.sel, e.conf);
                    end
                end
            end
            prev_conf = bus.confirmed_out;
        end
    end

    // Directed stimulus
    initial begin
        evt_t e;
        bus.btn_left_in    = 1'b0;
        bus.btn_right_in   = 1'b0;
        bus.btn_confirm_in = 1'b0;
        #1;
        check("reset_select", int'(bus.select_out), 0);
        check("reset_pulses", int'({bus.left_out, bus.right_out, bus.changed_out}), 0);
        check("reset_confirmed", int'(bus.confirmed_out), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_select", int'(bus.select_out), 0);
        check("idle_confirmed", int'(bus.confirmed_out), 0);

        // Five right steps 0 -> 5
        press(1, 10, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0);
        press(1, 10, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0);
        press(1, 10, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0);
        press(1, 10, 1'b1, 1'b0, 1'b1, 1'b1, 3'd4, 1'b0);
        press(1, 10, 1'b1, 1'b0, 1'b1, 1'b1, 3'd5, 1'b0);
        // Wrap both ways
        press(1, 10, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0);
        press(0, 10, 1'b1, 1'b1, 1'b0, 1'b1, 3'd5, 1'b0);
        check("after_wrap_select", int'(bus.select_out), 5);

        // Short glitches on left rejected
        press(0, 3, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        press(0, 3, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        check("glitch_select", int'(bus.select_out), 5);
        // Simultaneous left+right cancel
        press(3, 10, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        check("both_select", int'(bus.select_out), 5);

        // Down to 2, confirm, ignored rights, unconfirm
        press(0, 10, 1'b1, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0);
        press(0, 10, 1'b1, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0);
        press(0, 10, 1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0);
        press(2, 10, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1);
        press(1, 10, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        press(1, 10, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        check("confirmed_select", int'(bus.select_out), 2);
        check("confirmed_level", int'(bus.confirmed_out), 1);
        press(2, 10, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0);
        check("unconfirmed_level", int'(bus.confirmed_out), 0);

        // Up to 4, then reset mid-debounce with right held
        press(1, 10, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0);
        press(1, 10, 1'b1, 1'b0, 1'b1, 1'b1, 3'd4, 1'b0);
        check("pre_reset_select", int'(bus.select_out), 4);
        @(negedge clk);
        bus.btn_right_in = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_select", int'(bus.select_out), 0);
        check("async_reset_pulses", int'({bus.left_out, bus.right_out, bus.changed_out}), 0);
        check("async_reset_confirmed", int'(bus.confirmed_out), 0);
        repeat (2) @(negedge clk);
        e.cyc  = cyc + DEB + 3;
        e.l    = 1'b0;
        e.r    = 1'b1;
        e.ch   = 1'b1;
        e.sel  = 3'd1;
        e.conf = 1'b0;
        exp_q.push_back(e);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        bus.btn_right_in = 1'b0;
        repeat (15) @(negedge clk);
        check("post_reset_select", int'(bus.select_out), 1);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/filter_select_ctrl.md
Name: filter_select_ctrl

Overview:
- Button front-end for the filter-selection screen; sits directly upstream of the display-filter compositor.
- Synchronises and debounces raw left/right/confirm push-buttons, and keeps the registered selection index 0..5 with wrap-around.
- Implements a browse/confirm state machine.
- Drives single-cycle step pulses and a stable select index into the compositor, so the compositor holds no combinational selection feedback.

Parameters:
- DEBOUNCE_CYCLES, 742_500: consecutive stable cycles required before a debounced level changes; this is 10 ms at 74.25 MHz.
- NUM_OPTIONS, 6: number of selectable filter boxes; the index range is 0..NUM_OPTIONS-1.

Ports:
- clk_in  input  1  pixel clock; the only clock in the block.
- rst_n_in  input  1  reset, asynchronous, active-low.
- btn_left_in  input  1  raw left button, asynchronous to clk_in.
- btn_right_in  input  1  raw right button, asynchronous to clk_in.
- btn_confirm_in  input  1  raw confirm button, asynchronous to clk_in.
- left_out  output  1  one-cycle pulse per accepted left step.
- right_out  output  1  one-cycle pulse per accepted right step.
- select_out  output  3  current selection index, registered.
- changed_out  output  1  one-cycle pulse in the cycle select_out takes a new value.
- confirmed_out  output  1  level; high while in CONFIRMED.

Behaviour:
- Reset (rst_n_in low, async):
  - select_out=0, state=BROWSE.
  - left_out, right_out, changed_out and confirmed_out are all 0.
  - Synchroniser flops, debounced levels and debounce counters are cleared to 0.
  - Registers release on the first clk_in edge after rst_n_in rises.
- Per button, synchronise then debounce:
  - 2-flop synchroniser.
  - The counter resets whenever the synchronised value equals the debounced level; otherwise it increments.
  - When the count reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
  - A debounced 0->1 transition gives a one-cycle press pulse. Release gives no pulse.
  - Glitches shorter than DEBOUNCE_CYCLES cycles are fully rejected.
- Latency: a raw input that rises just before clk edge 0 and stays high produces its press pulse in cycle DEBOUNCE_CYCLES+2. The bench checks this exact value.
- FSM states: BROWSE, CONFIRMED.
- BROWSE:
  - Right press: select_out <= (select_out==NUM_OPTIONS-1) ? 0 : select_out+1.
  - Left press: select_out <= (select_out==0) ? NUM_OPTIONS-1 : select_out-1.
  - right_out/left_out are asserted in the same cycle select_out updates. changed_out is asserted in that cycle too.
  - Left and right presses in the same cycle: no step, no pulses.
  - Confirm press: move to CONFIRMED, and confirmed_out goes high next cycle. It takes priority over any step in that cycle, and select_out stays unchanged.
- CONFIRMED:
  - Left/right presses are ignored: no pulses and select_out frozen.
  - Confirm press returns the FSM to BROWSE.
- A button held through reset release produces one press pulse after debounce, like a new press.
- Width rules: the select index is 3 bits. Wrap is compared against NUM_OPTIONS-1 explicitly, never by natural overflow. Values 6 and 7 are unreachable.
- Reset asserted mid-debounce or mid-state clears everything immediately and emits no pulse.

Decomposition:
- Shared package filter_select_pkg:
  - enum sel_state_t {BROWSE, CONFIRMED}.
  - localparam NUM_FILTERS = 6.
  - localparam SEL_W = 3.
  - Box origin constants for arrow placement: x = 120/460/800, y = 334.
- Sub-module button_debounce:
  - Contains the synchroniser, counter, level register and rising-edge pulse.
  - Parameter DEBOUNCE_CYCLES.
  - Instantiated three times.

Test Plan (bench uses DEBOUNCE_CYCLES=4):
- Reset then idle 20 cycles -> select_out=0, confirmed_out=0, no pulses on left_out, right_out or changed_out.
- Right held high 10 cycles, five times -> select_out steps 1,2,3,4,5. Each step has exactly one right_out and one changed_out pulse, in cycle 6 after each rise.
- From select=5: one more right press -> select_out=0. Then one left press -> select_out=5.
- 3-cycle glitches on btn_left_in -> no left_out and select_out unchanged. Left and right debounced in the same cycle -> no step.
- Confirm press at select=2 -> confirmed_out=1. Right presses ignored and select_out stays 2. Second confirm -> BROWSE, confirmed_out=0.
- rst_n_in pulsed low asynchronously mid-debounce at select=4 -> outputs 0 immediately. With the button still held, exactly one pulse follows 6 cycles after reset release.
